multicast_dispatch_arbiter: RTL

- Shares one multicast command channel between NUM_REQ requesters. Each command is a data word plus a target mask.
- Round-robin arbitration picks one requester. The block latches its command and broadcasts the same data word to every target selected by the mask.
- Each target accepts independently. The block tracks still-pending targets and acknowledges the requester only once every selected target has accepted.
- Sits between command sources (e.g. DMA/CPU ports) and a bank of NUM_TARGET engines.

---
 rtl/multicast_dispatch_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/multicast_dispatch_arbiter.sv
// Round-robin arbiter that hands one multicast command channel to NUM_REQ requesters,
// broadcasts the latched data word to the masked targets and acknowledges once all accept.
module multicast_dispatch_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_TARGET = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*NUM_TARGET-1:0]    req_mask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_TARGET-1:0]            tgt_valid,
  input  logic [NUM_TARGET-1:0]            tgt_ready,
  output logic [NUM_TARGET*DATA_WIDTH-1:0] tgt_data,
  output logic                             busy,
  output logic [ID_WIDTH-1:0]              cur_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state_reg, state_next;
  logic [NUM_TARGET-1:0] pending_reg, pending_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [ID_WIDTH-1:0]   cur_id_reg, cur_id_next;
  logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;

  logic [NUM_TARGET-1:0] mask_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   cand     [NUM_REQ];
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;

  // cand[gi] is the requester index gi steps after rr_ptr, wrapped modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_req
    logic [ID_WIDTH:0] sum;
    assign mask_arr[gi] = req_mask[(gi+1)*NUM_TARGET-1 -: NUM_TARGET];
    assign data_arr[gi] = req_data[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign sum          = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi);
    assign cand[gi]     = (sum >= (ID_WIDTH+1)'(NUM_REQ))
                          ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_REQ))
                          : sum[ID_WIDTH-1:0];
  end

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        grant_found = 1'b1;
        grant_id    = cand[k];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    data_next    = data_reg;
    cur_id_next  = cur_id_reg;
    rr_ptr_next  = rr_ptr_reg;
    tgt_valid    = '0;
    req_ready    = '0;
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (en && grant_found) begin
          data_next    = data_arr[grant_id];
          cur_id_next  = grant_id;
          pending_next = mask_arr[grant_id];
          rr_ptr_next  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_next   = (mask_arr[grant_id] == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        tgt_valid    = pending_reg;
        pending_next = pending_reg & ~tgt_ready;
        if (pending_next == '0) state_next = DONE;
      end
      DONE: begin
        req_ready[cur_id_reg] = 1'b1;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs read as idle for the whole cycle in which reset is requested.
    if (rst) begin
      tgt_valid = '0;
      req_ready = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      data_reg    <= '0;
      cur_id_reg  <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      data_reg    <= data_next;
      cur_id_reg  <= cur_id_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  for (genvar gi = 0; gi < NUM_TARGET; gi++) begin : gen_tgt
    assign tgt_data[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] = rst ? '0 : data_reg;
  end

  assign cur_id = rst ? '0 : cur_id_reg;

endmodule
